// File: rtl/logic_axi4_lite_to_bus.sv
// -----------------------------------------------------------------------------
// logic_axi4_lite_to_bus
//
// Bridges an AXI4-Lite slave port onto a simple single-request bus. One
// transaction is in flight at a time. A write needs AW and W presented together.
// A read needs AR. When a write and a read are both eligible in the same cycle,
// the grant alternates between them.
//
// Optional feature (macro LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN):
//   When the macro is defined, a bus request that sees no bus_ready within
//   TIMEOUT request cycles is dropped. The slave then gets SLVERR, and a timed-out
//   read returns rdata = 0. When the macro is undefined, requests wait
//   indefinitely.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   slave_aw*/w*/b*       AXI4-Lite write address / data / response channels
//   slave_ar*/r*          AXI4-Lite read address / data channels
//   bus_write, bus_read   request strobes; they are held until bus_ready
//   bus_address/wdata/wstrb
//                         captured request fields, stable while requesting
//   bus_ready             completes the current request
//   bus_rdata, bus_error  sampled only in a request cycle with bus_ready = 1
//   dbg_state_o           current FSM state, for observation
//
// Handshake semantics: a channel transfers on a cycle where valid and ready are
// both 1. Once asserted, a valid output stays high with stable payload until it
// transfers. Readies are driven combinationally, only in IDLE and only for the
// granted direction.
// -----------------------------------------------------------------------------
module logic_axi4_lite_to_bus #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1,
  parameter int TIMEOUT       = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  // write address channel
  input  logic                      slave_awvalid,
  input  logic [ADDRESS_WIDTH-1:0]  slave_awaddr,
  input  logic [2:0]                slave_awprot,
  output logic                      slave_awready,
  // write data channel
  input  logic                      slave_wvalid,
  input  logic [DATA_BYTES*8-1:0]   slave_wdata,
  input  logic [DATA_BYTES-1:0]     slave_wstrb,
  output logic                      slave_wready,
  // write response channel
  output logic                      slave_bvalid,
  output logic [1:0]                slave_bresp,
  input  logic                      slave_bready,
  // read address channel
  input  logic                      slave_arvalid,
  input  logic [ADDRESS_WIDTH-1:0]  slave_araddr,
  input  logic [2:0]                slave_arprot,
  output logic                      slave_arready,
  // read data channel
  output logic                      slave_rvalid,
  output logic [DATA_BYTES*8-1:0]   slave_rdata,
  output logic [1:0]                slave_rresp,
  input  logic                      slave_rready,
  // simple bus
  output logic                      bus_write,
  output logic                      bus_read,
  output logic [ADDRESS_WIDTH-1:0]  bus_address,
  output logic [DATA_BYTES*8-1:0]   bus_wdata,
  output logic [DATA_BYTES-1:0]     bus_wstrb,
  input  logic                      bus_ready,
  input  logic [DATA_BYTES*8-1:0]   bus_rdata,
  input  logic                      bus_error,
  // observation
  output logic [2:0]                dbg_state_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_BRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_t;

  state_t                     state_q;
  logic                       last_write_q;  // 1: the last grant went to write
  logic                       bus_write_q;
  logic                       bus_read_q;
  logic [ADDRESS_WIDTH-1:0]   bus_address_q;
  logic [DATA_BYTES*8-1:0]    bus_wdata_q;
  logic [DATA_BYTES-1:0]      bus_wstrb_q;
  logic                       bvalid_q;
  logic [1:0]                 bresp_q;
  logic                       rvalid_q;
  logic [DATA_BYTES*8-1:0]    rdata_q;
  logic [1:0]                 rresp_q;

`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT);
  logic [TMR_W-1:0] timeout_cnt_q;
  logic             timeout_hit;
  // This is the last allowed request cycle. If bus_ready is absent here, the
  // request is abandoned.
  assign timeout_hit = (timeout_cnt_q == TMR_W'(TIMEOUT - 1));
`endif

  // prot carries no meaning on this bus. It is accepted and dropped.
  logic prot_unused;
  assign prot_unused = ^{slave_awprot, slave_arprot};

  // Grant arbitration. The reset term keeps every ready low while areset is
  // high, because state_q already reads IDLE during reset.
  logic is_idle;
  logic wr_eligible;
  logic rd_eligible;
  logic grant_write;
  logic grant_read;

  assign is_idle     = (state_q == ST_IDLE) && !areset;
  assign wr_eligible = slave_awvalid && slave_wvalid;
  assign rd_eligible = slave_arvalid;
  assign grant_write = is_idle && wr_eligible && (!rd_eligible || !last_write_q);
  assign grant_read  = is_idle && rd_eligible && (!wr_eligible ||  last_write_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      last_write_q  <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_read_q    <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= RESP_OKAY;
`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
      timeout_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_write) begin
            state_q       <= ST_WRITE;
            last_write_q  <= 1'b1;
            bus_write_q   <= 1'b1;
            bus_address_q <= slave_awaddr;
            bus_wdata_q   <= slave_wdata;
            bus_wstrb_q   <= slave_wstrb;
`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
            timeout_cnt_q <= '0;
`endif
          end else if (grant_read) begin
            state_q       <= ST_READ;
            last_write_q  <= 1'b0;
            bus_read_q    <= 1'b1;
            bus_address_q <= slave_araddr;
`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
            timeout_cnt_q <= '0;
`endif
          end
        end

        ST_WRITE: begin
          if (bus_ready) begin
            state_q     <= ST_BRESP;
            bus_write_q <= 1'b0;
            bvalid_q    <= 1'b1;
            bresp_q     <= bus_error ? RESP_SLVERR : RESP_OKAY;
          end
`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q     <= ST_BRESP;
            bus_write_q <= 1'b0;
            bvalid_q    <= 1'b1;
            bresp_q     <= RESP_SLVERR;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + TMR_W'(1);
          end
`endif
        end

        ST_READ: begin
          if (bus_ready) begin
            state_q    <= ST_RRESP;
            bus_read_q <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= bus_rdata;
            rresp_q    <= bus_error ? RESP_SLVERR : RESP_OKAY;
          end
`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q    <= ST_RRESP;
            bus_read_q <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= '0;
            rresp_q    <= RESP_SLVERR;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + TMR_W'(1);
          end
`endif
        end

        ST_BRESP: begin
          if (slave_bready) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end

        ST_RRESP: begin
          if (slave_rready) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign slave_awready = grant_write;
  assign slave_wready  = grant_write;
  assign slave_arready = grant_read;
  assign slave_bvalid  = bvalid_q;
  assign slave_bresp   = bresp_q;
  assign slave_rvalid  = rvalid_q;
  assign slave_rdata   = rdata_q;
  assign slave_rresp   = rresp_q;
  assign bus_write     = bus_write_q;
  assign bus_read      = bus_read_q;
  assign bus_address   = bus_address_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_logic_axi4_lite_to_bus.sv
// -----------------------------------------------------------------------------
// tb_logic_axi4_lite_to_bus
//
// Directed bench for the AXI4-Lite to simple-bus bridge. Inputs change 1 ns
// after the rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_logic_axi4_lite_to_bus;

  localparam int DB = 4;
  localparam int DW = DB * 8;
  localparam int AW = 8;
  localparam int TO = 16;

  // ---------------------------------------------------------------- clock/reset
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------- DUT signals
  logic          slave_awvalid, slave_awready, slave_wvalid, slave_wready;
  logic [AW-1:0] slave_awaddr, slave_araddr;
  logic [2:0]    slave_awprot, slave_arprot;
  logic [DW-1:0] slave_wdata, slave_rdata;
  logic [DB-1:0] slave_wstrb;
  logic          slave_bvalid, slave_bready, slave_arvalid, slave_arready;
  logic          slave_rvalid, slave_rready;
  logic [1:0]    slave_bresp, slave_rresp;
  logic          bus_write, bus_read, bus_ready, bus_error;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [DB-1:0] bus_wstrb;
  logic [2:0]    dbg_state;

  logic_axi4_lite_to_bus #(
    .DATA_BYTES   (DB),
    .ADDRESS_WIDTH(AW),
    .TIMEOUT      (TO)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .slave_awvalid(slave_awvalid),
    .slave_awaddr (slave_awaddr),
    .slave_awprot (slave_awprot),
    .slave_awready(slave_awready),
    .slave_wvalid (slave_wvalid),
    .slave_wdata  (slave_wdata),
    .slave_wstrb  (slave_wstrb),
    .slave_wready (slave_wready),
    .slave_bvalid (slave_bvalid),
    .slave_bresp  (slave_bresp),
    .slave_bready (slave_bready),
    .slave_arvalid(slave_arvalid),
    .slave_araddr (slave_araddr),
    .slave_arprot (slave_arprot),
    .slave_arready(slave_arready),
    .slave_rvalid (slave_rvalid),
    .slave_rdata  (slave_rdata),
    .slave_rresp  (slave_rresp),
    .slave_rready (slave_rready),
    .bus_write    (bus_write),
    .bus_read     (bus_read),
    .bus_address  (bus_address),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata),
    .bus_error    (bus_error),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];   // expected grant order: 1 = write, 0 = read

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    next_cycle();
    next_cycle();
    areset = 1'b0;
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_awready"}, slave_awready, 0);
    check_eq({tag, "_wready"},  slave_wready,  0);
    check_eq({tag, "_arready"}, slave_arready, 0);
    check_eq({tag, "_bvalid"},  slave_bvalid,  0);
    check_eq({tag, "_rvalid"},  slave_rvalid,  0);
    check_eq({tag, "_bresp"},   slave_bresp,   0);
    check_eq({tag, "_rresp"},   slave_rresp,   0);
    check_eq({tag, "_rdata"},   slave_rdata,   0);
    check_eq({tag, "_bus_wr"},  bus_write,     0);
    check_eq({tag, "_bus_rd"},  bus_read,      0);
    check_eq({tag, "_addr"},    bus_address,   0);
    check_eq({tag, "_wdata"},   bus_wdata,     0);
    check_eq({tag, "_wstrb"},   bus_wstrb,     0);
    check_eq({tag, "_state"},   dbg_state,     0);
  endtask

  // Presents AW+W for one cycle and checks that they are accepted together.
  // Afterwards the channel payload is scrambled so that only captured values
  // can appear on the bus.
  task automatic grant_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DB-1:0] s);
    slave_awvalid = 1'b1; slave_awaddr = a; slave_awprot = 3'b010;
    slave_wvalid  = 1'b1; slave_wdata  = d; slave_wstrb  = s;
    sample();
    check_eq("aw_ready", slave_awready, 1);
    check_eq("w_ready",  slave_wready,  1);
    check_eq("ar_ready_on_write", slave_arready, 0);
    next_cycle();
    slave_awvalid = 1'b0; slave_wvalid = 1'b0;
    slave_awaddr  = ~a;   slave_wdata  = ~d;  slave_wstrb = ~s;
  endtask

  task automatic grant_read(input logic [AW-1:0] a);
    slave_arvalid = 1'b1; slave_araddr = a; slave_arprot = 3'b101;
    sample();
    check_eq("ar_ready", slave_arready, 1);
    check_eq("aw_ready_on_read", slave_awready, 0);
    next_cycle();
    slave_arvalid = 1'b0; slave_araddr = ~a;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DB-1:0] s,
                           input int lat, input logic err, input int bdelay);
    logic [1:0] exp_resp;
    exp_resp = err ? 2'b10 : 2'b00;
    grant_write(a, d, s);
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        bus_ready = 1'b1; bus_error = err;
      end
      sample();
      check_eq("wr_req",     bus_write,   1);
      check_eq("wr_no_read", bus_read,    0);
      check_eq("wr_addr",    bus_address, a);
      check_eq("wr_data",    bus_wdata,   d);
      check_eq("wr_strb",    bus_wstrb,   s);
      next_cycle();
    end
    bus_ready = 1'b0; bus_error = 1'b0;
    for (int i = 0; i <= bdelay; i++) begin
      if (i == bdelay) slave_bready = 1'b1;
      sample();
      check_eq("wr_req_done", bus_write,    0);
      check_eq("bvalid",      slave_bvalid, 1);
      check_eq("bresp",       slave_bresp,  exp_resp);
      next_cycle();
    end
    slave_bready = 1'b0;
    sample();
    check_eq("bvalid_clear", slave_bvalid, 0);
    check_eq("idle_after_b", dbg_state,    0);
    next_cycle();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] rd,
                          input int lat, input logic err, input int rdelay);
    logic [1:0] exp_resp;
    exp_resp = err ? 2'b10 : 2'b00;
    grant_read(a);
    bus_rdata = ~rd;
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        bus_ready = 1'b1; bus_error = err; bus_rdata = rd;
      end
      sample();
      check_eq("rd_req",      bus_read,    1);
      check_eq("rd_no_write", bus_write,   0);
      check_eq("rd_addr",     bus_address, a);
      next_cycle();
    end
    // bus_ready stays high with junk data. It must be ignored in RRESP.
    bus_rdata = ~rd; bus_error = ~err;
    for (int i = 0; i <= rdelay; i++) begin
      if (i == rdelay) slave_rready = 1'b1;
      sample();
      check_eq("rd_req_done", bus_read,     0);
      check_eq("rvalid",      slave_rvalid, 1);
      check_eq("rdata",       slave_rdata,  rd);
      check_eq("rresp",       slave_rresp,  exp_resp);
      next_cycle();
    end
    slave_rready = 1'b0; bus_ready = 1'b0; bus_error = 1'b0;
    sample();
    check_eq("rvalid_clear", slave_rvalid, 0);
    check_eq("idle_after_r", dbg_state,    0);
    next_cycle();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin
    logic [0:0] exp_grant;
    areset        = 1'b1;
    slave_awvalid = 1'b1; slave_awaddr = 8'h11; slave_awprot = 3'b0;
    slave_wvalid  = 1'b1; slave_wdata  = 32'h1; slave_wstrb  = 4'h1;
    slave_arvalid = 1'b1; slave_araddr = 8'h22; slave_arprot = 3'b0;
    slave_bready  = 1'b0; slave_rready = 1'b0;
    bus_ready     = 1'b0; bus_rdata    = '0;    bus_error    = 1'b0;

    // Reset values, with every valid high so that ready gating is exercised.
    next_cycle();
    sample();
    check_reset_outputs("rst");
    next_cycle();
    slave_awvalid = 1'b0; slave_wvalid = 1'b0; slave_arvalid = 1'b0;
    areset = 1'b0;
    next_cycle();

    // Minimum-latency write, then a slow read whose response is held.
    axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
    axi_read (8'h08, 32'h1234_5678, 3, 1'b0, 5);

    // A partial strobe with some bus wait and response back-pressure.
    axi_write(8'hFC, 32'h0000_A55A, 4'h3, 2, 1'b0, 2);

    // Error completions.
    axi_write(8'h40, 32'h5555_AAAA, 4'hC, 1, 1'b1, 1);
    axi_read (8'h44, 32'hFEED_0001, 0, 1'b1, 0);

    // A lone W without AW must not be accepted.
    slave_wvalid = 1'b1; slave_wdata = 32'h77;
    sample();
    check_eq("w_alone_ready", slave_wready, 0);
    next_cycle();
    slave_wvalid = 1'b0;

`ifdef LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN
    // Timed-out write: bus_write is high for exactly TO cycles, then SLVERR.
    grant_write(8'h50, 32'h0101_0101, 4'hF);
    for (int i = 0; i < TO; i++) begin
      sample();
      check_eq("to_wr_req", bus_write, 1);
      next_cycle();
    end
    slave_bready = 1'b1;
    sample();
    check_eq("to_wr_dropped", bus_write,    0);
    check_eq("to_bvalid",     slave_bvalid, 1);
    check_eq("to_bresp",      slave_bresp,  2'b10);
    next_cycle();
    slave_bready = 1'b0;
    // Timed-out read: rdata is forced to zero.
    bus_rdata = 32'hA5A5_A5A5;
    grant_read(8'h54);
    for (int i = 0; i < TO; i++) begin
      sample();
      check_eq("to_rd_req", bus_read, 1);
      next_cycle();
    end
    slave_rready = 1'b1;
    sample();
    check_eq("to_rd_dropped", bus_read,     0);
    check_eq("to_rvalid",     slave_rvalid, 1);
    check_eq("to_rresp",      slave_rresp,  2'b10);
    check_eq("to_rdata",      slave_rdata,  0);
    next_cycle();
    slave_rready = 1'b0;
`else
    // With no timeout, the request is still pending after 1000 cycles.
    grant_write(8'h50, 32'h0101_0101, 4'hF);
    for (int i = 0; i < 1000; i++) next_cycle();
    sample();
    check_eq("wait_wr_req",    bus_write,    1);
    check_eq("wait_no_bvalid", slave_bvalid, 0);
    check_eq("wait_state",     dbg_state,    1);
    next_cycle();
    bus_ready = 1'b1;
    next_cycle();
    bus_ready = 1'b0; slave_bready = 1'b1;
    sample();
    check_eq("wait_bvalid", slave_bvalid, 1);
    check_eq("wait_bresp",  slave_bresp,  0);
    next_cycle();
    slave_bready = 1'b0;
`endif

    // Reset pulsed while a write is on the bus.
    grant_write(8'h30, 32'h0BAD_F00D, 4'h3);
    sample();
    check_eq("mid_wr_active", bus_write, 1);
    #2 areset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    next_cycle();
    areset    = 1'b0;
    bus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("post_rst_no_bvalid", slave_bvalid, 0);
      check_eq("post_rst_no_req",    bus_write,    0);
      next_cycle();
    end
    bus_ready = 1'b0;
    axi_write(8'h34, 32'hCAFE_F00D, 4'hF, 1, 1'b0, 0);

    // Continuous AW/W/AR after reset: grants alternate, starting with write.
    do_reset();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    slave_awvalid = 1'b1; slave_awaddr = 8'h60; slave_wvalid = 1'b1;
    slave_wdata   = 32'h600D_600D; slave_wstrb = 4'hF;
    slave_arvalid = 1'b1; slave_araddr = 8'h64;
    slave_bready  = 1'b1; slave_rready = 1'b1; bus_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      sample();
      check_eq("req_exclusive", {63'b0, bus_write & bus_read}, 0);
      if (slave_awready || slave_arready) begin
        check_eq("aw_w_paired", slave_awready, slave_wready);
        exp_grant = exp_q.pop_front();
        check_eq("grant_order", slave_awready, exp_grant);
      end
      next_cycle();
    end
    check_eq("grants_left", exp_q.size(), 0);
    slave_awvalid = 1'b0; slave_wvalid = 1'b0; slave_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("drain_exclusive", {63'b0, bus_write & bus_read}, 0);
      next_cycle();
    end
    sample();
    check_eq("drain_idle", dbg_state, 0);
    next_cycle();
    slave_bready = 1'b0; slave_rready = 1'b0; bus_ready = 1'b0;

    // ---------------------------------------------------------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_axi4_lite_to_bus.md
LOGIC_AXI4_LITE_TO_BUS -- requirements
Module: logic_axi4_lite_to_bus

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4: data width in bytes.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 1: address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 256: maximum bus wait in cycles; legal range ≥2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: aclk  input  1  clock; areset  input  1  reset.
REQ-005 SHALL have AXI4-Lite slave ports on aclk: slave_aw{valid,addr,prot,ready}, slave_w{valid,data,strb,ready}, slave_b{valid,resp,ready}, slave_ar{valid,addr,prot,ready}, slave_r{valid,data,resp,ready}, with the codebase access_t and response_t types.
REQ-006 SHALL have bus_write  output  1  write request.
REQ-007 SHALL have bus_read  output  1  read request.
REQ-008 SHALL have bus_address  output  ADDRESS_WIDTH  captured address.
REQ-009 SHALL have bus_wdata  output  DATA_BYTES*8  and bus_wstrb  output  DATA_BYTES: captured write data and strobes.
REQ-010 SHALL have bus_ready  input  1  completion of the current request.
REQ-011 SHALL have bus_rdata  input  DATA_BYTES*8  read data, and bus_error  input  1  error flag; both sampled when bus_ready=1.

Function
REQ-012 SHALL implement the FSM states IDLE, WRITE, READ, BRESP and RRESP.
REQ-013 IDLE write-eligible SHALL mean slave_awvalid=1 AND slave_wvalid=1; read-eligible SHALL mean slave_arvalid=1.
REQ-014 When both are eligible, grant SHALL alternate via a last-grant flag; the first grant after reset goes to write.
REQ-015 On a write grant in IDLE, slave_awready and slave_wready SHALL both be 1 in that same cycle; addr, data and strb SHALL be captured; next state WRITE.
REQ-016 On a read grant in IDLE, slave_arready SHALL be 1 in that same cycle; addr SHALL be captured; next state READ.
REQ-017 All ready outputs SHALL be 0 outside IDLE and in IDLE without a grant; AW/W SHALL never be accepted separately.
REQ-018 In WRITE, bus_write SHALL be 1 and bus_address/bus_wdata/bus_wstrb SHALL hold stable until the cycle bus_ready=1; next state BRESP.
REQ-019 In READ, bus_read SHALL be 1 and bus_address SHALL hold stable until the cycle bus_ready=1; bus_rdata SHALL be captured; next state RRESP.
REQ-020 bus_write and bus_read SHALL never both be 1.
REQ-021 bresp/rresp SHALL be SLVERR(2'b10) if bus_error=1 at completion, else OKAY(2'b00).
REQ-022 In BRESP, slave_bvalid SHALL be 1 with stable bresp until slave_bready=1; next state IDLE.
REQ-023 In RRESP, slave_rvalid SHALL be 1 with stable rdata/rresp until slave_rready=1; next state IDLE.
REQ-024 Minimum latency: grant at cycle 0, bus request at cycle 1, and with bus_ready=1 at cycle 1, valid response at cycle 2; a new grant is possible no earlier than the cycle after the response handshake.
REQ-025 bus_ready outside WRITE/READ SHALL be ignored.
REQ-026 prot SHALL be accepted and discarded.

Reset
REQ-027 While areset=1, all ready/valid outputs and bus_write/bus_read SHALL be 0, bus_address/bus_wdata/bus_wstrb SHALL be 0, slave_rdata SHALL be 0, resp outputs SHALL be OKAY, state SHALL be IDLE, and the last-grant flag SHALL select write next.
REQ-028 Reset asserted mid-transaction SHALL drop the transaction and produce no response after release.

Configuration
REQ-029 Macro LOGIC_AXI4_LITE_TO_BUS_TIMEOUT_EN defined: a counter SHALL clear on entry to WRITE/READ and increment each cycle without bus_ready. If bus_ready is not seen within TIMEOUT request cycles, the request SHALL be dropped and the block SHALL move to BRESP/RRESP with SLVERR; for a read, rdata SHALL be 0.
REQ-030 Macro not defined: no counter SHALL exist and WRITE/READ SHALL wait indefinitely.

Verification
REQ-031 Write addr=0x4, data=0xDEADBEEF, strb=0xF, bus_ready at the first request cycle -> bus_write for 1 cycle with those values; bvalid at cycle 2 with OKAY.
REQ-032 Read addr=0x8, bus_rdata=0x12345678, bus_ready after 3 cycles -> rvalid with 0x12345678/OKAY, held while rready=0 for 5 cycles.
REQ-033 AW, W and AR all valid continuously for 4 transactions -> grant order W,R,W,R; the two request outputs are never both high.
REQ-034 bus_error=1 at completion for a write and for a read -> bresp=SLVERR and rresp=SLVERR.
REQ-035 With the macro defined, TIMEOUT=16, bus_ready held 0 -> request drops after 16 cycles; SLVERR, rdata=0. Without the macro -> still waiting at cycle 1000.
REQ-036 areset pulsed during WRITE -> all outputs at reset values; no bvalid after release; the next transaction completes normally.
